serial_bit_feeder: RTL and testbench

- Upstream stage of the serial Moore sequence FSM.
- Accepts parallel words over a valid/ready handshake and serializes them, one bit per clock, onto the FSM's single-bit `in` input.
- A one-word pending buffer allows gapless back-to-back words.
- Drives a fixed idle level when no word is in flight.

---
 rtl/serial_bit_feeder.sv | 106 ++++++++++
 tb/tb_serial_bit_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: takes parallel words over a valid/ready handshake and
// shifts them out one bit per clock onto the downstream sequence FSM input.
// A single pending-word buffer lets consecutive words go out with no idle
// cycle between them.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0,
  localparam int  CW        = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done,
  output logic [CW-1:0]    bit_idx
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic             state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] pend_buf;
  logic             pend_full;
  logic [CW-1:0]    cnt;

  logic             transfer;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  // Handshake: ready whenever out of reset and the pending slot is empty
  assign data_ready = reset & ~pend_full;
  assign transfer   = data_valid & data_ready;
  assign last_bit   = (state == STATE_SHIFT) && (cnt == LAST_IDX);

  // Next shift-register value: move the next bit toward the output end
  always_comb begin
    shifted = shift_reg;
    if (MSB_FIRST != 0)
      shifted = {shift_reg[WIDTH-2:0], 1'b0};
    else
      shifted = {1'b0, shift_reg[WIDTH-1:1]};
  end

  // Outputs come only from registers so the downstream FSM sees a stable bit
  always_comb begin
    ser_out    = IDLE_BIT;
    ser_active = 1'b0;
    word_done  = 1'b0;
    bit_idx    = '0;
    if (state == STATE_SHIFT) begin
      ser_out    = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
      ser_active = 1'b1;
      word_done  = last_bit;
      bit_idx    = cnt;
    end
  end

  // Main sequencer: load, shift, chain pending or direct words, or go idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= STATE_IDLE;
      shift_reg <= '0;
      pend_buf  <= '0;
      pend_full <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (transfer) begin
            shift_reg <= data_in;
            cnt       <= '0;
            state     <= STATE_SHIFT;
          end
        end
        default: begin
          if (!last_bit) begin
            shift_reg <= shifted;
            cnt       <= cnt + CW'(1);
            if (transfer) begin
              pend_buf  <= data_in;
              pend_full <= 1'b1;
            end
          end else if (pend_full) begin
            shift_reg <= pend_buf;
            pend_full <= 1'b0;
            cnt       <= '0;
          end else if (transfer) begin
            shift_reg <= data_in;
            cnt       <= '0;
          end else begin
            cnt   <= '0;
            state <= STATE_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed checks of the serializer in MSB-first/idle-0
// and LSB-first/idle-1 configurations, including back-to-back words,
// backpressure on the pending slot and reset in the middle of a word.
module tb_serial_bit_feeder;

  logic       clock;
  logic       reset;

  logic [7:0] data0;
  logic       valid0;
  logic       ready0;
  logic       ser0;
  logic       active0;
  logic       done0;
  logic [2:0] idx0;

  logic [7:0] data1;
  logic       valid1;
  logic       ready1;
  logic       ser1;
  logic       active1;
  logic       done1;
  logic [2:0] idx1;

  int checkCount;
  int passCount;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .data_in(data0), .data_valid(valid0),
    .data_ready(ready0), .ser_out(ser0), .ser_active(active0),
    .word_done(done0), .bit_idx(idx0)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .data_in(data1), .data_valid(valid1),
    .data_ready(ready1), .ser_out(ser1), .ser_active(active1),
    .word_done(done1), .bit_idx(idx1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] data, input logic valid);
    if (sel == 0) begin
      data0  = data;
      valid0 = valid;
    end else begin
      data1  = data;
      valid1 = valid;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Directed test sequence
  initial begin
    logic [7:0]  w;
    logic [23:0] stream;
    logic        readyExp;

    checkCount = 0;
    passCount  = 0;
    reset = 1'b0;
    applyStimulus(0, 8'h00, 1'b0);
    applyStimulus(1, 8'h00, 1'b0);
    #2;

    $display("[TB] reset state");
    checkOutput("rst_ready0",  32'(ready0),  32'd0);
    checkOutput("rst_ser0",    32'(ser0),    32'd0);
    checkOutput("rst_active0", 32'(active0), 32'd0);
    checkOutput("rst_done0",   32'(done0),   32'd0);
    checkOutput("rst_idx0",    32'(idx0),    32'd0);
    checkOutput("rst_ser1",    32'(ser1),    32'd1);
    checkOutput("rst_ready1",  32'(ready1),  32'd0);
    applyStimulus(0, 8'h5A, 1'b1);
    tick();
    tick();
    checkOutput("rst_hold_ready0", 32'(ready0),  32'd0);
    checkOutput("rst_hold_active", 32'(active0), 32'd0);
    applyStimulus(0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready0", 32'(ready0), 32'd1);
    checkOutput("rel_ready1", 32'(ready1), 32'd1);

    $display("[TB] single word 0xB4 MSB first");
    tick();
    w = 8'hB4;
    applyStimulus(0, w, 1'b1);
    tick();
    applyStimulus(0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("b4_ser_%0d", i),    32'(ser0),    32'(w[7-i]));
      checkOutput($sformatf("b4_active_%0d", i), 32'(active0), 32'd1);
      checkOutput($sformatf("b4_idx_%0d", i),    32'(idx0),    32'(i));
      checkOutput($sformatf("b4_done_%0d", i),   32'(done0),   32'(i == 7));
      tick();
    end
    checkOutput("b4_idle_ser",    32'(ser0),    32'd0);
    checkOutput("b4_idle_active", 32'(active0), 32'd0);
    checkOutput("b4_idle_ready",  32'(ready0),  32'd1);

    $display("[TB] back-to-back 0xB4 0x0F with 0x3C under backpressure");
    tick();
    stream = {8'hB4, 8'h0F, 8'h3C};
    applyStimulus(0, 8'hB4, 1'b1);
    tick();
    applyStimulus(0, 8'h0F, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      readyExp = (c == 1) || (c == 9) || (c >= 17);
      checkOutput($sformatf("b2b_ser_%0d", c),   32'(ser0),   32'(stream[24-c]));
      checkOutput($sformatf("b2b_done_%0d", c),  32'(done0),  32'((c % 8) == 0));
      checkOutput($sformatf("b2b_ready_%0d", c), 32'(ready0), 32'(readyExp));
      checkOutput($sformatf("b2b_act_%0d", c),   32'(active0), 32'd1);
      if (c == 2)
        applyStimulus(0, 8'h3C, 1'b1);
      if (c == 10)
        applyStimulus(0, 8'h00, 1'b0);
      tick();
    end
    checkOutput("b2b_idle_ser",    32'(ser0),    32'd0);
    checkOutput("b2b_idle_active", 32'(active0), 32'd0);

    $display("[TB] LSB first, idle high, word 0x01");
    tick();
    w = 8'h01;
    applyStimulus(1, w, 1'b1);
    tick();
    applyStimulus(1, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("lsb_ser_%0d", i),  32'(ser1),  32'(w[i]));
      checkOutput($sformatf("lsb_idx_%0d", i),  32'(idx1),  32'(i));
      checkOutput($sformatf("lsb_done_%0d", i), 32'(done1), 32'(i == 7));
      tick();
    end
    checkOutput("lsb_idle_ser",    32'(ser1),    32'd1);
    checkOutput("lsb_idle_active", 32'(active1), 32'd0);

    $display("[TB] reset in the middle of 0xFF with 0xAA pending");
    tick();
    applyStimulus(0, 8'hFF, 1'b1);
    tick();
    applyStimulus(0, 8'hAA, 1'b1);
    checkOutput("mid_first_ser", 32'(ser0), 32'd1);
    tick();
    applyStimulus(0, 8'h00, 1'b0);
    checkOutput("mid_pend_ready", 32'(ready0), 32'd0);
    tick();
    tick();
    checkOutput("mid_bit3_ser", 32'(ser0), 32'd1);
    checkOutput("mid_bit3_idx", 32'(idx0), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ser",    32'(ser0),    32'd0);
    checkOutput("mid_rst_active", 32'(active0), 32'd0);
    checkOutput("mid_rst_ready",  32'(ready0),  32'd0);
    checkOutput("mid_rst_idx",    32'(idx0),    32'd0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 32'(ready0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("mid_stale_ser_%0d", i),    32'(ser0),    32'd0);
      checkOutput($sformatf("mid_stale_active_%0d", i), 32'(active0), 32'd0);
      tick();
    end

    $display("[TB] pattern 0xCC for the downstream FSM");
    w = 8'hCC;
    applyStimulus(0, w, 1'b1);
    tick();
    applyStimulus(0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("cc_ser_%0d", i), 32'(ser0), 32'(w[7-i]));
      tick();
    end
    checkOutput("cc_idle_ser",    32'(ser0),    32'd0);
    checkOutput("cc_idle_active", 32'(active0), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
